// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory controller: access sizes, FSM
// states and the store trace format.
package dm_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } dm_state_e;

    localparam string TRACE_FMT = "@%h: *%h <= %h";

    // Byte-lane write mask for a store of the given size at the given lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << lane;
            SZ_H:    m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// Request/response bundle between the CPU datapath (master) and the data
// memory (slave).
interface dm_ctrl_if;

    logic        REQ;
    logic        WE;
    logic [1:0]  SIZE;
    logic        UNS;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] PC;
    logic        READY;
    logic        RVALID;
    logic [31:0] RD;
    logic        EXC_LD;
    logic        EXC_ST;

    modport master (
        output REQ, WE, SIZE, UNS, A, WD, PC,
        input  READY, RVALID, RD, EXC_LD, EXC_ST
    );

    modport slave (
        input  REQ, WE, SIZE, UNS, A, WD, PC,
        output READY, RVALID, RD, EXC_LD, EXC_ST
    );

endinterface

// File: rtl/dm_lane.sv
// Byte-lane steering: merges store data into the old word, extracts and
// extends load data, and flags misaligned accesses.
module dm_lane
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wd,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lane,
    output logic [31:0] merged,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    logic [3:0]  mask_s;
    logic [31:0] wd_rep_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Replicate the right-justified store data onto every lane, then mask it in.
    always_comb begin
        mask_s   = lane_mask(size, lane);
        wd_rep_s = (size == SZ_B) ? {4{wd[7:0]}} : {2{wd[15:0]}};
        if (size == SZ_W) begin
            wd_rep_s = wd;
        end else begin
            wd_rep_s = wd_rep_s;
        end
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = mask_s[i] ? wd_rep_s[8*i +: 8] : old_word[8*i +: 8];
        end
    end

    // Load extraction with sign/zero extension, plus alignment check.
    always_comb begin
        byte_s     = old_word[{lane, 3'b000} +: 8];
        half_s     = lane[1] ? old_word[31:16] : old_word[15:0];
        ld_data    = old_word;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                ld_data = uns ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            end
            SZ_H: begin
                misaligned = lane[0];
                ld_data    = uns ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            end
            SZ_W: begin
                misaligned = (lane != 2'b00);
                ld_data    = old_word;
            end
            default: begin
                misaligned = 1'b1;
                ld_data    = old_word;
            end
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Parametrised data memory with post-reset clear engine, registered loads,
// signed/unsigned extension and access exceptions.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH  = 3072,
    parameter int ADDR_W = 14,
    parameter int TRACE  = 1
) (
    input logic      CLK,
    input logic      RESET,
    dm_ctrl_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    dm_state_e        state_r;
    logic [IDX_W-1:0] clr_idx_r;
    logic             ready_r;
    logic             rvalid_r;
    logic             exc_ld_r;
    logic             exc_st_r;
    logic [31:0]      rd_r;
    logic [31:0]      mem_r [DEPTH];

    logic [WIX_W-1:0] widx_s;
    logic [1:0]       lane_s;
    logic [IDX_W-1:0] idx_s;
    logic             oor_s;
    logic             misal_s;
    logic             bad_s;
    logic             acc_s;
    logic             st_ok_s;
    logic             ld_ok_s;
    logic             ld_bad_s;
    logic             st_bad_s;
    logic [31:0]      old_word_s;
    logic [31:0]      merged_s;
    logic [31:0]      ld_data_s;

    assign widx_s = bus.A[ADDR_W-1:2];
    assign lane_s = bus.A[1:0];

    // Address decode and access classification; out-of-range reads use index 0.
    always_comb begin
        oor_s = ((bus.A >> ADDR_W) != 32'd0) || (32'(widx_s) >= 32'(DEPTH));
        if (oor_s) begin
            idx_s = '0;
        end else begin
            idx_s = widx_s[IDX_W-1:0];
        end
        acc_s    = bus.REQ && ready_r;
        bad_s    = oor_s || misal_s;
        st_ok_s  = acc_s && bus.WE && !bad_s;
        ld_ok_s  = acc_s && !bus.WE && !bad_s;
        st_bad_s = acc_s && bus.WE && bad_s;
        ld_bad_s = acc_s && !bus.WE && bad_s;
    end

    assign old_word_s = mem_r[idx_s];

    dm_lane u_lane (
        .old_word   (old_word_s),
        .wd         (bus.WD),
        .size       (bus.SIZE),
        .uns        (bus.UNS),
        .lane       (lane_s),
        .merged     (merged_s),
        .ld_data    (ld_data_s),
        .misaligned (misal_s)
    );

    // Control FSM: clear sequencing, handshake and registered response outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r   <= ST_INIT;
            clr_idx_r <= '0;
            ready_r   <= 1'b0;
            rvalid_r  <= 1'b0;
            exc_ld_r  <= 1'b0;
            exc_st_r  <= 1'b0;
            rd_r      <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_INIT: begin
                    rvalid_r <= 1'b0;
                    exc_ld_r <= 1'b0;
                    exc_st_r <= 1'b0;
                    if (clr_idx_r == LAST_IDX) begin
                        state_r   <= ST_IDLE;
                        ready_r   <= 1'b1;
                        clr_idx_r <= '0;
                    end else begin
                        ready_r   <= 1'b0;
                        clr_idx_r <= clr_idx_r + IDX_W'(1);
                    end
                end
                ST_IDLE: begin
                    ready_r  <= 1'b1;
                    rvalid_r <= ld_ok_s;
                    exc_ld_r <= ld_bad_s;
                    exc_st_r <= st_bad_s;
                    if (ld_ok_s) begin
                        rd_r <= ld_data_s;
                    end
                end
                default: begin
                    state_r   <= ST_INIT;
                    clr_idx_r <= '0;
                    ready_r   <= 1'b0;
                    rvalid_r  <= 1'b0;
                    exc_ld_r  <= 1'b0;
                    exc_st_r  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: clear engine owns the write port during INIT.
    always_ff @(posedge CLK) begin
        if (state_r == ST_INIT) begin
            mem_r[clr_idx_r] <= 32'h0000_0000;
        end else if (st_ok_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    // Simulation trace of every committed store.
    always_ff @(posedge CLK) begin
        if ((TRACE != 0) && st_ok_s) begin
            $write("%s\n", $sformatf(TRACE_FMT, bus.PC, bus.A, merged_s));
        end
    end

    assign bus.READY  = ready_r;
    assign bus.RVALID = rvalid_r;
    assign bus.RD     = rd_r;
    assign bus.EXC_LD = exc_ld_r;
    assign bus.EXC_ST = exc_st_r;

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: a byte-addressed reference memory predicts
// every response; a separate monitor checks pulses, data and timing.
module tb_dm_ctrl;
    import dm_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 14;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    dm_ctrl_if bus ();

    dm_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TRACE(1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  pulse;   // {RVALID, EXC_LD, EXC_ST}
        logic [31:0] rd;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  ref_mem [DEPTH*4];
    logic [31:0] last_rd = 32'h0;
    bit          in_idle = 1'b0;
    int          cyc = 0;
    int          pc_ctr = 0;
    int          drv_checks = 0, drv_fails = 0;
    int          mon_checks = 0, mon_fails = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        drv_checks++;
        if (got !== exp) begin
            drv_fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue one access (called just after a rising edge) and predict its outcome.
    task automatic acc(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
        int nb;
        bit bad;
        logic [31:0] v;
        bus.REQ  = 1'b1;
        bus.WE   = we;
        bus.SIZE = size;
        bus.UNS  = uns;
        bus.A    = a;
        bus.WD   = wd;
        bus.PC   = 32'h0000_1000 + 32'(pc_ctr * 4);
        pc_ctr++;
        if (bus.READY === 1'b1) begin
            nb  = (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
            bad = (size == SZ_RSV) || ((a % nb) != 0) || (a >= DEPTH * 4);
            if (bad) begin
                sbq.push_back('{pulse: (we ? 3'b001 : 3'b010), rd: last_rd, due: cyc + 1});
            end else if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
                if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                last_rd = v;
                sbq.push_back('{pulse: 3'b100, rd: v, due: cyc + 1});
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        bus.REQ = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        bus.REQ = 1'b0;
        for (int k = 0; k < 16 && sbq.size() > 0; k++) begin
            @(posedge CLK);
            #1;
        end
        chk("sb_drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic read_all();
        for (int w = 0; w < DEPTH; w++) acc(1'b0, SZ_W, 1'b0, 32'(w * 4), 32'h0);
        drain();
    endtask

    // Reset, optionally re-asserted abort_at cycles into the clear, then time READY.
    task automatic do_reset(input int abort_at);
        int n;
        in_idle  = 1'b0;
        bus.REQ  = 1'b1;
        bus.WE   = 1'b1;
        bus.SIZE = SZ_W;
        bus.A    = 32'h0;
        bus.WD   = 32'hDEAD_BEEF;
        @(negedge CLK);
        RESET = 1'b0;
        #2;
        chk("rst_ready", 32'(bus.READY), 32'd0);
        chk("rst_rvalid", 32'(bus.RVALID), 32'd0);
        chk("rst_exc_ld", 32'(bus.EXC_LD), 32'd0);
        chk("rst_exc_st", 32'(bus.EXC_ST), 32'd0);
        chk("rst_rd", bus.RD, 32'h0);
        if (abort_at > 0) begin
            @(negedge CLK);
            RESET = 1'b1;
            repeat (abort_at) @(posedge CLK);
            #1;
            chk("ready_mid_init", 32'(bus.READY), 32'd0);
            RESET = 1'b0;
            #2;
            chk("ready_reabort", 32'(bus.READY), 32'd0);
        end
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        n = 0;
        while (n < 4 * DEPTH && bus.READY !== 1'b1) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("ready_rise_cycles", 32'(n), 32'(DEPTH));
        bus.REQ = 1'b0;
        for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
        last_rd = 32'h0;
        sbq.delete();
        in_idle = 1'b1;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a response pulse.
    always @(negedge CLK) begin
        logic [2:0] got;
        exp_t e;
        if (RESET) begin
            got = {bus.RVALID, bus.EXC_LD, bus.EXC_ST};
            if (in_idle) begin
                mon_checks++;
                if (bus.READY !== 1'b1) begin
                    mon_fails++;
                    $display("FAIL ready_idle: got %b expected 1 at cycle %0d", bus.READY, cyc);
                end
            end
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                mon_checks++;
                mon_fails++;
                $display("FAIL missing_pulse: got none expected %b due cycle %0d", e.pulse, e.due);
            end
            if (got != 3'b000) begin
                mon_checks++;
                if (sbq.size() == 0) begin
                    mon_fails++;
                    $display("FAIL spurious_pulse: got %b rd %h expected none at cycle %0d", got, bus.RD, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (got !== e.pulse || bus.RD !== e.rd || e.due != cyc) begin
                        mon_fails++;
                        $display("FAIL response: got pulse %b rd %h cycle %0d expected pulse %b rd %h cycle %0d",
                                 got, bus.RD, cyc, e.pulse, e.rd, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;
        int          r;
        bus.REQ = 1'b0; bus.WE = 1'b0; bus.SIZE = SZ_W; bus.UNS = 1'b0;
        bus.A = 32'h0; bus.WD = 32'h0; bus.PC = 32'h0;

        // Clear timing, REQ ignored during INIT, every word reads zero.
        do_reset(0);
        read_all();
        do_reset(8);
        read_all();

        // Signed/unsigned byte and half loads.
        acc(1'b1, SZ_W, 1'b0, 32'h10, 32'h8000_00FF);
        acc(1'b0, SZ_B, 1'b0, 32'h10, 32'h0);
        acc(1'b0, SZ_B, 1'b1, 32'h10, 32'h0);
        acc(1'b0, SZ_H, 1'b0, 32'h12, 32'h0);
        acc(1'b0, SZ_H, 1'b1, 32'h12, 32'h0);
        drain();

        // Partial-word stores merge into the existing word.
        acc(1'b1, SZ_W, 1'b0, 32'h20, 32'h1122_3344);
        acc(1'b1, SZ_B, 1'b0, 32'h21, 32'hFFFF_FFAB);
        acc(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
        acc(1'b1, SZ_H, 1'b0, 32'h22, 32'h1234_BEEF);
        acc(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
        drain();

        // Misaligned, reserved-size and out-of-range accesses.
        acc(1'b0, SZ_W, 1'b0, 32'h6, 32'h0);
        acc(1'b1, SZ_H, 1'b0, 32'h3, 32'h0000_5555);
        acc(1'b1, SZ_RSV, 1'b0, 32'h8, 32'h7777_7777);
        acc(1'b1, SZ_W, 1'b0, 32'h40, 32'hFFFF_FFFF);
        acc(1'b0, SZ_W, 1'b0, 32'h1000_0000, 32'h0);
        acc(1'b0, SZ_H, 1'b1, 32'h1000_0012, 32'h0);
        drain();
        read_all();

        // REQ held high: alternating store/load to one word.
        for (int i = 0; i < 20; i++) begin
            acc(1'b1, SZ_W, 1'b0, 32'h30, 32'(i) * 32'h0101_0101 + 32'h7);
            acc(1'b0, SZ_W, 1'b0, 32'h30, 32'h0);
        end
        drain();

        // Randomised mix of sizes, lanes and legal/illegal addresses.
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? SZ_B : (r < 6) ? SZ_H : (r < 9) ? SZ_W : SZ_RSV;
            r  = $urandom_range(0, 9);
            if (r < 7)       ad = 32'($urandom_range(0, DEPTH * 4 - 1));
            else if (r == 7) ad = 32'h40 + 32'($urandom_range(0, 255));
            else if (r == 8) ad = 32'h1000_0000 | 32'($urandom_range(0, 63));
            else             ad = $urandom;
            acc(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        drain();
        read_all();

        // Reset from IDLE must re-clear the whole array.
        do_reset(0);
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", drv_checks + mon_checks, drv_fails + mon_fails);
        $finish;
    end

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Parametrised data memory for the single-cycle/multi-cycle CPU datapath. It succeeds the fixed 3072-word, combinational-read data memory with the following changes:
- depth and address width are parameters;
- reads are registered, with a request/ready handshake;
- loads can be signed or unsigned;
- misaligned and out-of-range accesses raise an exception instead of silently corrupting data;
- after reset, a sequential clear engine zeroes the array one word per cycle.

The block sits between the ALU address output and the writeback mux.

## Interface
- DEPTH, 3072: number of 32-bit words.
- ADDR_W, 14: byte-address bits decoded; must satisfy 2^(ADDR_W-2) ≥ DEPTH.
- TRACE, 1: when 1, every committed store prints a simulation trace line.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ  in  1  access request.
- WE  in  1  1 = store, 0 = load; sampled with REQ.
- SIZE  in  2  00 byte, 01 halfword, 10 word; 11 reserved, treated as misaligned.
- UNS  in  1  load zero-extends when 1, sign-extends when 0; ignored for word and for stores.
- A  in  32  byte address.
- WD  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- PC  in  32  instruction PC, used only for the trace.
- READY  out  1  request accepted this cycle when REQ&&READY.
- RVALID  out  1  one-cycle pulse: RD holds load result.
- RD  out  32  extended load data; holds its value between loads.
- EXC_LD  out  1  one-cycle pulse: the previous load was rejected.
- EXC_ST  out  1  one-cycle pulse: the previous store was rejected.

## Operation
FSM states: INIT and IDLE.

INIT
- Entered on reset.
- Clear counter `clr_idx` starts at 0. Each cycle writes 0 to `mem[clr_idx]`, then increments.
- When `clr_idx == DEPTH-1` has been written, move to IDLE.
- READY=0 throughout; REQ is ignored and nothing is queued.

IDLE
- READY=1.
- An accepted access decodes word index `A[ADDR_W-1:2]` and byte lane `A[1:0]`.

Access check:
- Misaligned: half with A[0]=1; word with A[1:0]≠0; SIZE=11.
- Out of range: word index ≥ DEPTH, or any of A[31:ADDR_W] ≠ 0.
- A rejected access leaves memory untouched. The matching EXC_* pulses the next cycle; RVALID stays 0 and RD is unchanged.

Store (accepted and legal):
- The word is written at the accepting edge. Only the addressed lanes change: byte → lane A[1:0]; half → lanes 1:0 or 3:2 per A[1]; word → all four.
- If TRACE, print "@PC: *A <= merged_word" (hex, 8 digits, full merged word) at that edge.

Load (accepted and legal):
- The word is read at the accepting edge.
- Lane selection and extension are registered into RD; RVALID=1 the following cycle.

Other rules:
- Back-to-back access to the same word: a store at edge N followed by a load accepted at edge N+1 returns the stored data. There is no read-during-write conflict because only one access is accepted per cycle.

## Timing
- Reset values: READY=0, RVALID=0, EXC_LD=0, EXC_ST=0, RD=32'h0, state=INIT, clr_idx=0.
- Reset asserted mid-INIT or mid-IDLE: asynchronous return to INIT with clr_idx=0; the clear restarts from scratch.
- After reset release: READY rises on cycle DEPTH+1, i.e. exactly DEPTH clear cycles.
- Load latency 1: accept at edge N; RD, RVALID valid after edge N+1 for one cycle.
- Store latency 0: memory visible to a load accepted at edge N+1.
- Exception pulse appears one cycle after acceptance, the same slot as RVALID.
- Throughput: one access per cycle in IDLE. REQ held high produces back-to-back accesses.

## Structure
- Package `dm_pkg`: SIZE encodings (SZ_B, SZ_H, SZ_W), FSM state typedef (ST_INIT, ST_IDLE), and the trace format string.
- One combinational sub-module, `dm_lane`: given the old word, WD, SIZE, UNS and A[1:0], it produces the merged store word, the extended load data and the misaligned flag. This keeps `dm_ctrl` to the FSM, clear counter, array and output registers.

## Test plan
1. Reset with DEPTH=16: READY=0 for 16 cycles, then 1. Every word then reads 0. Assert RESET at cycle 8 → READY stays 0 until 16 cycles after release.
2. SW 0x8000_00FF at A=0x10, then LB A=0x10 → RD=0xFFFF_FFFF. LBU A=0x10 → 0x0000_00FF. LH A=0x12 → 0xFFFF_8000. LHU A=0x12 → 0x0000_8000. Each with RVALID one cycle after accept.
3. SB 0xAB to A=0x21 over word 0x1122_3344 → word 0x1122_AB44. Trace shows "@<PC>: *00000021 <= 1122ab44". SH 0xBEEF at A=0x22 → 0xBEEF_AB44.
4. LW A=0x6 and SH A=0x3 → EXC_LD, then EXC_ST pulse. Memory is unchanged, RD unchanged, RVALID=0.
5. With DEPTH=16, SW to A=0x40 and LW A=0x1000_0000 → EXC_ST / EXC_LD. No array word modified.
6. REQ held high over alternating SW/LW to the same address with incrementing data → every load returns the immediately preceding store's data. One RVALID every second cycle, and READY never drops.
